hazard_controller: RTL and testbench
====================================

# hazard_controller

Central stall/flush sequencer for the 5-stage pipeline. It drives the STALL/FLUSH inputs of the IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers, and the PC hold. It resolves load-use hazards, taken-branch squashes and multi-cycle data-memory waits, and declares a sticky hang when memory stays busy too long. It sits beside the pipeline registers and is the only source of their STALL/FLUSH controls.

## Interface
- WAIT_LIMIT, 15: maximum consecutive MemBusy cycles tolerated; more than this sets Hung.
- CLOCK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- ID_RS  in  5  rs field of the instruction in ID.
- ID_RT  in  5  rt field of the instruction in ID.
- ID_UsesRT  in  1  instruction in ID reads rt.
- EXE_MemRead  in  1  instruction in EXE is a load.
- EXE_WriteRegister  in  5  destination of the instruction in EXE.
- BranchTaken  in  1  branch/jump resolved taken in ID this cycle.
- MemBusy  in  1  data memory has not completed the current MEM access.
- PC_Hold  out  1  PC does not update.
- STALL_IFID, FLUSH_IFID  out  1 each  IF/ID controls.
- STALL_IDEXE, FLUSH_IDEXE  out  1 each  ID/EXE controls.
- STALL_EXEMEM  out  1  EXE/MEM hold.
- FLUSH_MEMWB  out  1  inserts a bubble into MEM/WB.
- Hung  out  1  sticky memory timeout flag (registered).
- StallCycles  out  16  count of cycles with PC_Hold=1 (registered, saturating).

## Operation
- The FSM has states RUN, MEM_WAIT and HUNG. wait_cnt is $clog2(WAIT_LIMIT+1) bits wide.
- RUN transitions:
  - MemBusy=1: go to MEM_WAIT, wait_cnt<=1.
  - Otherwise: stay in RUN.
- MEM_WAIT transitions:
  - MemBusy=0: go to RUN, wait_cnt<=0.
  - MemBusy=1 and wait_cnt==WAIT_LIMIT: go to HUNG, Hung<=1.
  - MemBusy=1 otherwise: wait_cnt<=wait_cnt+1.
- HUNG: absorbing; exited only by RESET.
- mem_stall = MemBusy | (state==HUNG). Outputs are combinational from state and current inputs (Mealy).
- When mem_stall=1, all other hazards are ignored:
  - PC_Hold=1, STALL_IFID=1, STALL_IDEXE=1, STALL_EXEMEM=1, FLUSH_MEMWB=1.
  - FLUSH_IFID=0, FLUSH_IDEXE=0.
- Load-use (lu) = EXE_MemRead & (EXE_WriteRegister!=0) & ((EXE_WriteRegister==ID_RS) | (ID_UsesRT & (EXE_WriteRegister==ID_RT))).
  - When lu=1 and mem_stall=0: PC_Hold=1, STALL_IFID=1, FLUSH_IDEXE=1 (bubble into EXE); all others 0.
  - A concurrent BranchTaken is suppressed. The branch re-resolves next cycle with forwarded data.
- When BranchTaken=1, lu=0 and mem_stall=0: FLUSH_IFID=1 only. The squashed fetch becomes a bubble; PC is not held.
- With no hazard, all stall/flush outputs and PC_Hold are 0.
- Priority: mem_stall > lu > BranchTaken.
- StallCycles increments on every rising edge where PC_Hold=1 and holds at 16'hFFFF.
- Register 0 never creates a load-use hazard.

## Timing
- While RESET=1: state=RUN, wait_cnt=0, Hung=0, StallCycles=0.
  - All combinational outputs are forced to 0 regardless of inputs.
- Reset asserted mid-wait or in HUNG clears everything immediately (asynchronously). The first edge after deassertion evaluates from RUN.
- Control outputs have zero-cycle latency from inputs. The FSM, Hung and StallCycles update on the rising CLOCK edge.
- A memory wait of N consecutive MemBusy cycles:
  - Stalls the pipeline for exactly N cycles.
  - The first cycle with MemBusy=0 evaluates normal hazards, even though state still reads MEM_WAIT in that cycle.
- Hung rises at the edge ending busy cycle WAIT_LIMIT+1.
  - N=WAIT_LIMIT never hangs.
  - Once in HUNG, MemBusy dropping does not release the pipeline.
- Back-to-back waits: MemBusy 1,0,1 gives two separate waits, and wait_cnt restarts at 1.
- A single-cycle load-use always spends exactly one cycle. The following cycle sees the load in MEM, so lu=0.

## Test plan
- Reset, then ID_RS=5, EXE_MemRead=1, EXE_WriteRegister=5 -> same cycle PC_Hold=STALL_IFID=FLUSH_IDEXE=1, others 0; StallCycles=1 after the edge.
- EXE_WriteRegister=0 with ID_RS=0 and EXE_MemRead=1 -> no stall; ID_UsesRT=0, ID_RT=7, EXE_WriteRegister=7 -> no stall.
- Load-use and BranchTaken together -> FLUSH_IFID=0, FLUSH_IDEXE=1; next cycle with lu=0 and BranchTaken=1 -> FLUSH_IFID=1 only.
- MemBusy high 3 cycles, with lu and BranchTaken also high:
  - Expected: 3 cycles of full stall with FLUSH_MEMWB=1 and no ID/IF flushes.
  - Cycle 4: normal hazard outputs.
  - StallCycles=3 (plus 1 if lu is still true), Hung=0.
- WAIT_LIMIT=15 with MemBusy high for 15 cycles -> Hung=0. With MemBusy high for 16 cycles -> Hung=1 after the 16th edge; the stall persists after MemBusy=0.
- Assert RESET in HUNG -> Hung=0, StallCycles=0 and all outputs 0 immediately without a clock edge. Preload StallCycles near 16'hFFFF via a long stall -> it saturates and does not wrap.

Source files
------------

// File: rtl/hazard_controller.sv
// hazard_controller: stall/flush sequencer for load-use, branch squash and data-memory waits with sticky hang detect.
module hazard_controller #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [4:0]  ID_RS,
    input  logic [4:0]  ID_RT,
    input  logic        ID_UsesRT,
    input  logic        EXE_MemRead,
    input  logic [4:0]  EXE_WriteRegister,
    input  logic        BranchTaken,
    input  logic        MemBusy,
    output logic        PC_Hold,
    output logic        STALL_IFID,
    output logic        FLUSH_IFID,
    output logic        STALL_IDEXE,
    output logic        FLUSH_IDEXE,
    output logic        STALL_EXEMEM,
    output logic        FLUSH_MEMWB,
    output logic        Hung,
    output logic [15:0] StallCycles
);
    localparam int CW = $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);
    typedef enum logic [1:0] {RUN, MEM_WAIT, HUNG} state_t;
    state_t state, stateNext;
    logic [CW-1:0] waitCnt, waitCntNext;
    logic memStall, loadUse, active;
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state       <= RUN;
            waitCnt     <= '0;
            Hung        <= 1'b0;
            StallCycles <= 16'd0;
        end else begin
            state       <= stateNext;
            waitCnt     <= waitCntNext;
            Hung        <= Hung | (stateNext == HUNG);
            StallCycles <= (PC_Hold && StallCycles != 16'hFFFF) ? StallCycles + 16'd1 : StallCycles;
        end
    end
    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        if (state == RUN && MemBusy) begin
            stateNext   = MEM_WAIT;
            waitCntNext = CW'(1);
        end else if (state == MEM_WAIT) begin
            if (!MemBusy) begin
                stateNext   = RUN;
                waitCntNext = '0;
            end else if (waitCnt == LIMIT) begin
                stateNext = HUNG;
            end else begin
                waitCntNext = waitCnt + CW'(1);
            end
        end
    end
    // Register 0 is hardwired, so a load targeting it can never feed ID.
    assign loadUse = EXE_MemRead && EXE_WriteRegister != 5'd0 &&
                     (EXE_WriteRegister == ID_RS || (ID_UsesRT && EXE_WriteRegister == ID_RT));
    assign memStall = MemBusy || state == HUNG;
    assign active = !RESET;
    assign PC_Hold      = active && (memStall || loadUse);
    assign STALL_IFID   = active && (memStall || loadUse);
    assign STALL_IDEXE  = active && memStall;
    assign STALL_EXEMEM = active && memStall;
    assign FLUSH_MEMWB  = active && memStall;
    assign FLUSH_IDEXE  = active && !memStall && loadUse;
    assign FLUSH_IFID   = active && !memStall && !loadUse && BranchTaken;
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: vector table plus scoreboard queue for hazard_controller.
module tb_hazard_controller;
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       usesRt;
        logic       memRead;
        logic [4:0] wr;
        logic       br;
        logic       busy;
        logic [6:0] exp;
    } vec_t;
    // {PC_Hold, STALL_IFID, FLUSH_IFID, STALL_IDEXE, FLUSH_IDEXE, STALL_EXEMEM, FLUSH_MEMWB}
    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] LU   = 7'b1100100;
    localparam logic [6:0] BR   = 7'b0010000;
    localparam logic [6:0] MEM  = 7'b1101011;
    logic CLOCK = 1'b0, RESET = 1'b1;
    logic [4:0] ID_RS = '0, ID_RT = '0, EXE_WriteRegister = '0;
    logic ID_UsesRT = 1'b0, EXE_MemRead = 1'b0, BranchTaken = 1'b0, MemBusy = 1'b0;
    logic PC_Hold, STALL_IFID, FLUSH_IFID, STALL_IDEXE, FLUSH_IDEXE, STALL_EXEMEM, FLUSH_MEMWB, Hung;
    logic [15:0] StallCycles;
    logic [6:0] outs;
    int checks = 0, failures = 0;
    int expStall = 0, busyRun = 0;
    logic expHung = 1'b0;
    vec_t sb[$];
    vec_t tbl[17];
    vec_t v;

    hazard_controller #(.WAIT_LIMIT(15)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .ID_RS(ID_RS), .ID_RT(ID_RT), .ID_UsesRT(ID_UsesRT),
        .EXE_MemRead(EXE_MemRead), .EXE_WriteRegister(EXE_WriteRegister),
        .BranchTaken(BranchTaken), .MemBusy(MemBusy), .PC_Hold(PC_Hold),
        .STALL_IFID(STALL_IFID), .FLUSH_IFID(FLUSH_IFID), .STALL_IDEXE(STALL_IDEXE),
        .FLUSH_IDEXE(FLUSH_IDEXE), .STALL_EXEMEM(STALL_EXEMEM), .FLUSH_MEMWB(FLUSH_MEMWB),
        .Hung(Hung), .StallCycles(StallCycles)
    );

    assign outs = {PC_Hold, STALL_IFID, FLUSH_IFID, STALL_IDEXE, FLUSH_IDEXE, STALL_EXEMEM, FLUSH_MEMWB};
    always #5 CLOCK = ~CLOCK;

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t x);
        ID_RS = x.rs; ID_RT = x.rt; ID_UsesRT = x.usesRt; EXE_MemRead = x.memRead;
        EXE_WriteRegister = x.wr; BranchTaken = x.br; MemBusy = x.busy;
    endtask

    // Called at posedge+1: drive, push expectation, compare outputs at negedge, registers after the edge.
    task automatic step(input vec_t x, input string name);
        vec_t e;
        apply(x);
        sb.push_back(x);
        @(negedge CLOCK);
        e = sb.pop_front();
        chk({name, "_outs"}, {9'd0, outs}, {9'd0, e.exp});
        if (e.exp[6] && expStall < 65535) expStall++;
        busyRun = e.busy ? busyRun + 1 : 0;
        if (busyRun > 15) expHung = 1'b1;
        @(posedge CLOCK);
        #1;
        chk({name, "_hung"}, {15'd0, Hung}, {15'd0, expHung});
        chk({name, "_stalls"}, StallCycles, 16'(expStall));
    endtask

    initial begin
        //         rs     rt     uRt   mRd   wr     br    busy  exp
        tbl[0]  = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, LU};
        tbl[1]  = '{5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, NONE};
        tbl[2]  = '{5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, NONE};
        tbl[3]  = '{5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, LU};
        tbl[4]  = '{5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, NONE};
        tbl[5]  = '{5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, LU};
        tbl[6]  = '{5'd9, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, BR};
        tbl[7]  = '{5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, NONE};
        tbl[8]  = '{5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1, MEM};
        tbl[9]  = '{5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1, MEM};
        tbl[10] = '{5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1, MEM};
        tbl[11] = '{5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, LU};
        tbl[12] = '{5'd4, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, BR};
        tbl[13] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, MEM};
        tbl[14] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, NONE};
        tbl[15] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, MEM};
        tbl[16] = '{5'd2, 5'd2, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, LU};

        apply(tbl[0]);
        MemBusy = 1'b1;
        #3;
        chk("reset_outs", {9'd0, outs}, 16'd0);
        @(posedge CLOCK);
        @(posedge CLOCK);
        #1;
        chk("reset_hung", {15'd0, Hung}, 16'd0);
        chk("reset_stalls", StallCycles, 16'd0);
        RESET = 1'b0;

        for (int i = 0; i < 17; i++) step(tbl[i], $sformatf("vec%0d", i));

        v = '0;
        v.busy = 1'b1; v.exp = MEM;
        for (int i = 0; i < 15; i++) step(v, $sformatf("wait15_%0d", i));
        v.busy = 1'b0; v.exp = NONE;
        step(v, "wait15_release");

        v.busy = 1'b1; v.exp = MEM;
        for (int i = 0; i < 16; i++) step(v, $sformatf("wait16_%0d", i));
        v.busy = 1'b0; v.exp = MEM;
        step(v, "hung_hold0");
        v.rs = 5'd6; v.wr = 5'd6; v.memRead = 1'b1; v.br = 1'b1;
        step(v, "hung_hold1");

        repeat (65534 - expStall) @(posedge CLOCK);
        #1;
        chk("sat_pre", StallCycles, 16'hFFFE);
        @(posedge CLOCK);
        #1;
        chk("sat_top", StallCycles, 16'hFFFF);
        repeat (3) @(posedge CLOCK);
        #1;
        chk("sat_hold", StallCycles, 16'hFFFF);
        chk("sat_outs", {9'd0, outs}, {9'd0, MEM});

        MemBusy = 1'b1;
        #2;
        RESET = 1'b1;
        #1;
        chk("areset_outs", {9'd0, outs}, 16'd0);
        chk("areset_hung", {15'd0, Hung}, 16'd0);
        chk("areset_stalls", StallCycles, 16'd0);
        @(posedge CLOCK);
        #1;
        RESET = 1'b0;
        expStall = 0; expHung = 1'b0; busyRun = 0;
        v = '0; v.exp = NONE;
        step(v, "post_reset_idle");
        step(tbl[0], "post_reset_lu");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
